vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel-enable divider, h/v counters, registered sync/de/colour.
// Define VGA_TEST_PATTERN_EN to add the internal 8-bar colour pattern selected by test_mode.
module vga_timing_gen #(
    parameter int   COLOR_W  = 4,
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HC_W     = $clog2(H_TOTAL),
    localparam int  VC_W     = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] in_r,
    input  logic [COLOR_W-1:0] in_g,
    input  logic [COLOR_W-1:0] in_b,
    input  logic               test_mode,
    output logic [COLOR_W-1:0] pix_r,
    output logic [COLOR_W-1:0] pix_g,
    output logic [COLOR_W-1:0] pix_b,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [HC_W-1:0]    x,
    output logic [VC_W-1:0]    y,
    output logic               pix_tick,
    output logic               frame_start
);
    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  H_LAST    = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]  H_VIS_END = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]  HS_START  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]  HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0]  V_LAST    = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]  V_VIS_END = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]  VS_START  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]  VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [HC_W-1:0]    h_cnt_q, h_cnt_d;
    logic [VC_W-1:0]    v_cnt_q, v_cnt_d;
    logic [COLOR_W-1:0] pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               de_q, de_d, frame_start_q, frame_start_d;

    logic               tick;
    logic               visible, in_hs, in_vs;
    logic [COLOR_W-1:0] src_r, src_g, src_b;

    assign tick    = !rst && (div_cnt_q == DIV_LAST);
    assign visible = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    assign in_hs   = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign in_vs   = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [HC_W-1:0] bar_raw;
    logic [2:0]      bar_idx;

    always_comb begin
        bar_raw = h_cnt_q / HC_W'(BAR_W);
        bar_idx = (bar_raw > HC_W'(7)) ? 3'd7 : bar_raw[2:0];
    end

    // White..black bar order is the inverted index mapped as g=~idx[2], r=~idx[1], b=~idx[0].
    assign src_r = test_mode ? {COLOR_W{~bar_idx[1]}} : in_r;
    assign src_g = test_mode ? {COLOR_W{~bar_idx[2]}} : in_g;
    assign src_b = test_mode ? {COLOR_W{~bar_idx[0]}} : in_b;
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign src_r = in_r;
    assign src_g = in_g;
    assign src_b = in_b;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q (or a constant) before any branch, so no latch is inferred.
        div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_r_d       = pix_r_q;
        pix_g_d       = pix_g_q;
        pix_b_d       = pix_b_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VC_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + HC_W'(1);
            end
            de_d          = visible;
            hsync_d       = in_hs ? HS_POL : ~HS_POL;
            vsync_d       = in_vs ? VS_POL : ~VS_POL;
            pix_r_d       = visible ? src_r : '0;
            pix_g_d       = visible ? src_g : '0;
            pix_b_d       = visible ? src_b : '0;
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign pix_tick    = tick;
    assign frame_start = frame_start_q;

endmodule
